// File: rtl/rx_mac_buffer_writer_pkg.sv
// Shared constants, FSM encoding and length-header layout for the RX MAC buffer writer.
`ifndef BF
`define BF 9
`endif

package rx_mac_buffer_writer_pkg;

  localparam int unsigned RX_BUF_AW       = `BF + 1;
  localparam logic [15:0] RX_MAX_LEN      = 16'd9216;
  localparam int unsigned LEN_HDR_LEN_MSB = 15;

  typedef enum logic [5:0] {
    StIdle   = 6'b000001,
    StData   = 6'b000010,
    StHdr    = 6'b000100,
    StCommit = 6'b001000,
    StDrop   = 6'b010000,
    StRewind = 6'b100000
  } wr_state_e;

  function automatic logic [63:0] len_header(input logic [LEN_HDR_LEN_MSB:0] len);
    logic [63:0] hdr;
    hdr = '0;
    hdr[LEN_HDR_LEN_MSB:0] = len;
    return hdr;
  endfunction

endpackage

// File: rtl/rx_mac_buffer_writer_popcount.sv
// Decodes contiguous-from-bit-0 MAC byte enables into a byte count 0..8.
module rx_byte_popcount (
  input  logic [7:0] byte_en,
  output logic [3:0] count
);

  logic legal;

  always_comb begin
    count = 4'd0;
    legal = 1'b1;
    case (byte_en)
      8'h00:   count = 4'd0;
      8'h01:   count = 4'd1;
      8'h03:   count = 4'd2;
      8'h07:   count = 4'd3;
      8'h0F:   count = 4'd4;
      8'h1F:   count = 4'd5;
      8'h3F:   count = 4'd6;
      8'h7F:   count = 4'd7;
      8'hFF:   count = 4'd8;
      default: legal = 1'b0;
    endcase
  end

  // Holes in the enables are a MAC protocol violation; they count as no bytes.
  always_comb begin
    contiguous_enables: assert (legal);
  end

endmodule

// File: rtl/rx_mac_buffer_writer.sv
// Writes MAC RX frames into the packet ring behind a length header; commits good frames only.
module rx_mac_buffer_writer
  import rx_mac_buffer_writer_pkg::*;
#(
  parameter int unsigned BUF_AW  = RX_BUF_AW,
  parameter logic [15:0] MAX_LEN = RX_MAX_LEN
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [63:0]       rx_data,
  input  logic [7:0]        rx_data_valid,
  input  logic              rx_good_frame,
  input  logic              rx_bad_frame,
  input  logic [BUF_AW-1:0] commited_rd_address,
  output logic [BUF_AW-1:0] wr_addr,
  output logic [63:0]       wr_data,
  output logic              wr_en,
  output logic [BUF_AW-1:0] commited_wr_address,
  output logic [31:0]       dropped_frames
);

  wr_state_e         state;
  logic [BUF_AW-1:0] hdr_addr;
  logic [BUF_AW-1:0] cursor;
  logic [15:0]       byte_cnt;

  logic [3:0]        beat_bytes;
  logic [BUF_AW-1:0] full_addr;
  logic [16:0]       len_next;
  logic              beat;
  logic              len_over;
  logic              end_pulse;
  logic              rewind_go;

  rx_byte_popcount u_popcount (
    .byte_en (rx_data_valid),
    .count   (beat_bytes)
  );

  // Writing at full_addr would make a full ring indistinguishable from an empty one.
  assign full_addr = commited_rd_address - BUF_AW'(1);
  assign beat      = |rx_data_valid;
  assign len_next  = {1'b0, byte_cnt} + {13'b0, beat_bytes};
  assign len_over  = len_next > {1'b0, MAX_LEN};
  assign end_pulse = rx_good_frame | rx_bad_frame;
  assign rewind_go = ((state == StData) && !rx_good_frame && rx_bad_frame) ||
                     ((state == StDrop) && end_pulse);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= StIdle;
      wr_en               <= 1'b0;
      wr_addr             <= '0;
      wr_data             <= '0;
      commited_wr_address <= '0;
      dropped_frames      <= '0;
      hdr_addr            <= '0;
      cursor              <= '0;
      byte_cnt            <= '0;
    end else begin
      wr_en <= 1'b0;
      unique case (state)
        StIdle: begin
          if (beat) begin
            hdr_addr <= commited_wr_address;
            byte_cnt <= len_next[15:0];
            if (commited_wr_address == full_addr ||
                commited_wr_address + BUF_AW'(1) == full_addr || len_over) begin
              state <= StDrop;
            end else begin
              wr_en   <= 1'b1;
              wr_addr <= commited_wr_address + BUF_AW'(1);
              wr_data <= rx_data;
              cursor  <= commited_wr_address + BUF_AW'(2);
              state   <= StData;
            end
          end
        end
        StData: begin
          if (rx_good_frame) begin
            wr_en   <= 1'b1;
            wr_addr <= hdr_addr;
            wr_data <= len_header(byte_cnt);
            state   <= StHdr;
          end else if (rx_bad_frame) begin
            state <= StRewind;
          end else if (beat) begin
            if (cursor == full_addr || len_over) begin
              state <= StDrop;
            end else begin
              wr_en    <= 1'b1;
              wr_addr  <= cursor;
              wr_data  <= rx_data;
              cursor   <= cursor + BUF_AW'(1);
              byte_cnt <= len_next[15:0];
            end
          end
        end
        StHdr: begin
          // The header is in the ring now, so the frame can be exposed.
          commited_wr_address <= cursor;
          byte_cnt            <= '0;
          state               <= StCommit;
        end
        StCommit: state <= StIdle;
        StDrop: begin
          if (end_pulse) state <= StRewind;
        end
        StRewind: state <= StIdle;
        default:  state <= StIdle;
      endcase

      if (rewind_go) begin
        if (dropped_frames != 32'hFFFF_FFFF) dropped_frames <= dropped_frames + 32'd1;
        cursor   <= commited_wr_address;
        byte_cnt <= '0;
      end
    end
  end

endmodule
